// File: rtl/arb_pkg.sv
// Shared types and helpers for the prio_sel_arbiter block.
package arb_pkg;

  // Widest request vector the index helper supports.
  localparam int ARB_MAX_REQ = 16;

  typedef enum logic [1:0] {
    ARB_PRIORITY = 2'd0,
    ARB_RR       = 2'd1,
    ARB_UNIQUE   = 2'd2
  } arb_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Binary index of a one-hot vector. An all-zero vector maps to 0.
  function automatic logic [3:0] onehot2idx(input logic [ARB_MAX_REQ-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for prio_sel_arbiter.
// Produces a one-hot winner for the configured mode plus any/multi flags.
module arb_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  arb_mode_e        mode,
  output logic [N_REQ-1:0] winner,
  output logic             any,
  output logic             multi
);

  // One extra bit so rr_ptr + offset never overflows before the wrap.
  localparam int SUM_W = IDX_W + 1;

  logic [N_REQ-1:0] win_fixed;
  logic [N_REQ-1:0] win_rr;

  // Fixed priority: lowest set index wins.
  always_comb begin
    logic found;
    win_fixed = '0;
    found     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && !found) begin
        win_fixed[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Round robin: first set index at or after rr_ptr, wrapping N_REQ-1 -> 0.
  always_comb begin
    logic             found;
    logic [SUM_W-1:0] pos;
    win_rr = '0;
    found  = 1'b0;
    pos    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = SUM_W'(rr_ptr) + SUM_W'(i);
      if (pos >= SUM_W'(N_REQ)) pos = pos - SUM_W'(N_REQ);
      if (req[pos[IDX_W-1:0]] && !found) begin
        win_rr[pos[IDX_W-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
  end

  assign any    = |req;
  assign multi  = (req & (req - N_REQ'(1))) != '0;
  // UNIQUE only ever grants a single-hot request, so lowest-index is exact there.
  assign winner = (mode == ARB_RR) ? win_rr : win_fixed;

endmodule

// File: rtl/prio_sel_arbiter.sv
// N-way request arbiter with registered one-hot grant held until released.
// Modes: fixed priority, round robin, strict unique (multi-hot flagged, not granted).
// Optional macro ARB_TIMEOUT_EN: revoke a grant held for TIMEOUT cycles and pulse err_timeout.
//
// state   | meaning
// IDLE    | no grant; arbitrate whenever req != 0
// GRANT   | grant held stable until done (or hold timeout)
// RELEASE | grant dropped; one dead cycle before re-arbitration
module prio_sel_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MODE    = 0,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     done,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     gnt_valid,
  output logic                     err_multi,
  output logic [CNT_W-1:0]         viol_cnt,
  output logic                     err_timeout
);

  localparam int              IDX_W    = $clog2(N_REQ);
  localparam arb_mode_e       ARB_MODE = arb_mode_e'(2'(MODE));
  localparam logic [CNT_W-1:0] VIOL_MAX = '1;

  if (N_REQ < 2 || N_REQ > ARB_MAX_REQ || MODE < 0 || MODE > 2 || TIMEOUT < 1) begin : g_bad_cfg
    $fatal(1, "prio_sel_arbiter: illegal N_REQ, MODE or TIMEOUT");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             err_multi_q, err_multi_d;
  logic [CNT_W-1:0] viol_q, viol_d;
  logic [IDX_W-1:0] rr_q, rr_d;

  logic [N_REQ-1:0] winner;
  logic             any;
  logic             multi;
  logic [IDX_W-1:0] win_idx;
  logic             hold_expired;

  arb_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_q),
    .mode   (ARB_MODE),
    .winner (winner),
    .any    (any),
    .multi  (multi)
  );

  assign win_idx = IDX_W'(onehot2idx(ARB_MAX_REQ'(winner)));

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(TIMEOUT + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              err_to_q, err_to_d;

  assign hold_expired = (hold_q == HOLD_W'(TIMEOUT - 1));
  assign err_timeout  = err_to_q;

  // Hold counter: zero while idle so it starts at 0 on GRANT entry; done wins over timeout.
  always_comb begin
    hold_d   = hold_q;
    err_to_d = 1'b0;
    if (state_q == IDLE) begin
      hold_d = '0;
    end else if (state_q == GRANT) begin
      hold_d   = hold_q + HOLD_W'(1);
      err_to_d = hold_expired && !done;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      err_to_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      err_to_q <= err_to_d;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign err_timeout  = 1'b0;
`endif

  // Next-state and next-output computation for the grant FSM.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    err_multi_d = 1'b0;
    viol_d      = viol_q;
    rr_d        = rr_q;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        if (ARB_MODE == ARB_UNIQUE && multi) begin
          err_multi_d = 1'b1;
          if (viol_q != VIOL_MAX) viol_d = viol_q + CNT_W'(1);
        end else if (any) begin
          state_d = GRANT;
          gnt_d   = winner;
          idx_d   = win_idx;
          valid_d = 1'b1;
          rr_d    = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
      end
      GRANT: begin
        if (done || hold_expired) begin
          state_d = RELEASE;
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, round-robin pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      err_multi_q <= 1'b0;
      viol_q      <= '0;
      rr_q        <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      err_multi_q <= err_multi_d;
      viol_q      <= viol_d;
      rr_q        <= rr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign err_multi = err_multi_q;
  assign viol_cnt  = viol_q;

endmodule
